// File: rtl/write_s_block.sv
// rtl/write_s_block.sv - IDCT write-S stage: clips S samples from DP-RAM and writes packed pixels to SRAM.
// One block per start: 16x16 in Y mode, 8x8 in U/V mode, one SRAM write per cycle with no gaps.
module write_s_block #(
  parameter logic [17:0] Y_BASE = 18'd0,
  parameter logic [17:0] U_BASE = 18'd38400,
  parameter logic [17:0] V_BASE = 18'd57600
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        start,
  input  logic        Y_finished,
  input  logic        U_finished,
  input  logic [4:0]  Rb,
  input  logic [4:0]  Cb,
  output logic [7:0]  DP_RAM_address,
  input  logic [31:0] DP_RAM_read_data,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LEADIN = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [7:0]  dp_addr_q, dp_addr_d;
  logic [17:0] sram_addr_q, sram_addr_d;
  logic [15:0] sram_data_q, sram_data_d;
  logic        we_n_q, we_n_d;
  logic        done_q, done_d;
  logic [6:0]  k_q, k_d;
  logic        is_y_q, is_y_d;
  logic        is_v_q, is_v_d;
  logic [4:0]  rb_q, rb_d;
  logic [4:0]  cb_q, cb_d;

  logic [8:0]  row;
  logic [17:0] row_off;
  logic [17:0] col_off;
  logic [17:0] base;
  logic [17:0] cur_addr;
  logic [6:0]  last_k;

  function automatic logic [7:0] clip(input logic [15:0] s);
    if (s[15])
      clip = 8'd0;
    else if (s[14:8] != 7'd0)
      clip = 8'd255;
    else
      clip = s[7:0];
  endfunction

  // Row pitch 160 = 128 + 32 (Y), 80 = 64 + 16 (U/V).
  always_comb begin
    if (is_y_q) begin
      row     = {rb_q, 4'b0000} + {5'd0, k_q[6:3]};
      row_off = {2'b00, row, 7'd0} + {4'd0, row, 5'd0};
      col_off = {10'd0, cb_q, 3'b000} + {15'd0, k_q[2:0]};
      base    = Y_BASE;
    end else begin
      row     = {1'b0, rb_q, 3'b000} + {6'd0, k_q[4:2]};
      row_off = {3'd0, row, 6'd0} + {5'd0, row, 4'd0};
      col_off = {11'd0, cb_q, 2'b00} + {16'd0, k_q[1:0]};
      base    = is_v_q ? V_BASE : U_BASE;
    end
    cur_addr = base + row_off + col_off;
    last_k   = is_y_q ? 7'd127 : 7'd31;
  end

  always_comb begin
    state_d     = state_q;
    dp_addr_d   = dp_addr_q;
    sram_addr_d = sram_addr_q;
    sram_data_d = sram_data_q;
    we_n_d      = we_n_q;
    done_d      = done_q;
    k_d         = k_q;
    is_y_d      = is_y_q;
    is_v_d      = is_v_q;
    rb_d        = rb_q;
    cb_d        = cb_q;
    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        we_n_d = 1'b1;
        if (start) begin
          is_y_d    = ~Y_finished;
          is_v_d    = Y_finished & U_finished;
          rb_d      = Rb;
          cb_d      = Cb;
          k_d       = 7'd0;
          dp_addr_d = 8'd0;
          state_d   = S_LEADIN;
        end
      end
      S_LEADIN: begin
        dp_addr_d = 8'd1;
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        sram_data_d = {clip(DP_RAM_read_data[31:16]), clip(DP_RAM_read_data[15:0])};
        sram_addr_d = cur_addr;
        we_n_d      = 1'b0;
        k_d         = k_q + 7'd1;
        // Address runs two ahead of the captured word; hold it at the last valid entry.
        if (dp_addr_q != {1'b0, last_k})
          dp_addr_d = dp_addr_q + 8'd1;
        if (k_q == last_k)
          state_d = S_FINISH;
      end
      default: begin
        we_n_d  = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= S_IDLE;
      dp_addr_q   <= 8'd0;
      sram_addr_q <= 18'd0;
      sram_data_q <= 16'd0;
      we_n_q      <= 1'b1;
      done_q      <= 1'b0;
      k_q         <= 7'd0;
      is_y_q      <= 1'b0;
      is_v_q      <= 1'b0;
      rb_q        <= 5'd0;
      cb_q        <= 5'd0;
    end else begin
      state_q     <= state_d;
      dp_addr_q   <= dp_addr_d;
      sram_addr_q <= sram_addr_d;
      sram_data_q <= sram_data_d;
      we_n_q      <= we_n_d;
      done_q      <= done_d;
      k_q         <= k_d;
      is_y_q      <= is_y_d;
      is_v_q      <= is_v_d;
      rb_q        <= rb_d;
      cb_q        <= cb_d;
    end
  end

  assign DP_RAM_address  = dp_addr_q;
  assign SRAM_address    = sram_addr_q;
  assign SRAM_write_data = sram_data_q;
  assign SRAM_we_n       = we_n_q;
  assign done            = done_q;

endmodule

// File: tb/tb_write_s_block.sv
// tb/tb_write_s_block.sv - directed bench for write_s_block with a DP-RAM model.
// Each block run checks write strobe, address, data and done timing edge by edge.
module tb_write_s_block;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        start;
  logic        Y_finished;
  logic        U_finished;
  logic [4:0]  Rb;
  logic [4:0]  Cb;
  logic [7:0]  DP_RAM_address;
  logic [31:0] DP_RAM_read_data;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic        done;

  int errors = 0;
  int checks = 0;
  logic [31:0] mem [0:255];
  logic [15:0] wdata [0:127];
  logic [17:0] waddr [0:127];
  int nw;
  int de;
  int cnt;
  int got;

  always #5 Clock = ~Clock;

  // Registered-read DP-RAM: address from edge e appears as data sampled at edge e+2.
  always @(posedge Clock) DP_RAM_read_data <= mem[DP_RAM_address];

  write_s_block dut (
    .Clock            (Clock),
    .Resetn           (Resetn),
    .start            (start),
    .Y_finished       (Y_finished),
    .U_finished       (U_finished),
    .Rb               (Rb),
    .Cb               (Cb),
    .DP_RAM_address   (DP_RAM_address),
    .DP_RAM_read_data (DP_RAM_read_data),
    .SRAM_address     (SRAM_address),
    .SRAM_write_data  (SRAM_write_data),
    .SRAM_we_n        (SRAM_we_n),
    .done             (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] exp_addr(input logic yf, input logic uf,
                                           input logic [4:0] rb, input logic [4:0] cb, input int k);
    int r, j, a;
    if (!yf) begin
      r = k / 8; j = k % 8;
      a = (16 * int'(rb) + r) * 160 + 8 * int'(cb) + j;
    end else begin
      r = k / 4; j = k % 4;
      a = (uf ? 57600 : 38400) + (8 * int'(rb) + r) * 80 + 4 * int'(cb) + j;
    end
    return a[17:0];
  endfunction

  function automatic logic [7:0] exp_pix(input logic [15:0] s);
    int v;
    v = int'($signed(s));
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return v[7:0];
  endfunction

  task automatic run_block(input logic yf, input logic uf, input logic [4:0] rb, input logic [4:0] cb,
                           input int ign1, input int ign2, input logic b2b);
    int n;
    n = yf ? 32 : 128;
    nw = 0;
    de = -1;
    @(negedge Clock);
    Y_finished = yf; U_finished = uf; Rb = rb; Cb = cb; start = 1'b1;
    @(posedge Clock);
    for (int e = 1; e <= n + 5; e++) begin
      @(negedge Clock);
      start = (e == ign1) || (e == ign2) || (b2b && e == n + 3);
      if (e <= n + 1) begin
        Y_finished = ~yf; U_finished = ~uf; Rb = 5'(e); Cb = ~cb;
      end else begin
        Y_finished = yf; U_finished = uf; Rb = rb; Cb = cb;
      end
      @(posedge Clock);
      #1;
      if (e <= n + 4) begin
        chk("we_n", {31'd0, SRAM_we_n}, (e >= 2 && e <= n + 1) ? 32'd0 : 32'd1);
        chk("done", {31'd0, done}, (e == n + 2) ? 32'd1 : 32'd0);
      end else begin
        chk("b2b_we_n", {31'd0, SRAM_we_n}, b2b ? 32'd0 : 32'd1);
        if (b2b) chk("b2b_addr", {14'd0, SRAM_address}, {14'd0, exp_addr(yf, uf, rb, cb, 0)});
      end
      if (!SRAM_we_n && e <= n + 1 && nw < 128) begin
        wdata[nw] = SRAM_write_data;
        waddr[nw] = SRAM_address;
        chk("addr", {14'd0, SRAM_address}, {14'd0, exp_addr(yf, uf, rb, cb, nw)});
        chk("data", {16'd0, SRAM_write_data}, {16'd0, exp_pix(mem[nw][31:16]), exp_pix(mem[nw][15:0])});
        nw++;
      end
      if (done && de < 0) de = e;
    end
    start = 1'b0;
  endtask

  initial begin
    Resetn = 1'b0; start = 1'b0; Y_finished = 1'b0; U_finished = 1'b0; Rb = 5'd0; Cb = 5'd0;
    for (int i = 0; i < 256; i++) mem[i] = {16'(i), 16'(i + 1)};
    #12;
    chk("rst_we_n", {31'd0, SRAM_we_n}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_addr", {14'd0, SRAM_address}, 32'd0);
    chk("rst_data", {16'd0, SRAM_write_data}, 32'd0);
    chk("rst_dp", {24'd0, DP_RAM_address}, 32'd0);
    @(negedge Clock);
    Resetn = 1'b1;

    // T1: Y block at origin, word k = {k, k+1}
    run_block(1'b0, 1'b0, 5'd0, 5'd0, -1, -1, 1'b0);
    chk("t1_count", nw, 128);
    chk("t1_word0", {16'd0, wdata[0]}, 32'h0001);
    chk("t1_addr7", {14'd0, waddr[7]}, 32'd7);
    chk("t1_row1", {14'd0, waddr[8]}, 32'd160);
    chk("t1_last", {14'd0, waddr[127]}, 32'd2407);
    chk("t1_done_edge", de, 130);

    // T2: clipping vectors
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = {16'hFFF6, 16'h012C};
    mem[1] = {16'd128, 16'd255};
    mem[2] = {16'h8000, 16'h7FFF};
    run_block(1'b1, 1'b0, 5'd3, 5'd5, -1, -1, 1'b0);
    chk("t2_neg_big", {16'd0, wdata[0]}, 32'h00FF);
    chk("t2_inrange", {16'd0, wdata[1]}, 32'h80FF);
    chk("t2_extremes", {16'd0, wdata[2]}, 32'h00FF);

    // T3: U block, Rb=14 Cb=19
    run_block(1'b1, 1'b0, 5'd14, 5'd19, -1, -1, 1'b0);
    chk("t3_count", nw, 32);
    chk("t3_first", {14'd0, waddr[0]}, 32'd47436);
    chk("t3_last", {14'd0, waddr[31]}, 32'd47999);
    chk("t3_done_edge", de, 34);

    // T4: V block at origin, followed by a back-to-back start on done
    run_block(1'b1, 1'b1, 5'd0, 5'd0, -1, -1, 1'b1);
    chk("t4_first", {14'd0, waddr[0]}, 32'd57600);
    chk("t4_row1", {14'd0, waddr[4]}, 32'd57680);
    chk("t4_last", {14'd0, waddr[31]}, 32'd58163);
    got = 0;
    for (int i = 0; i < 200 && got == 0; i++) begin
      @(posedge Clock);
      #1;
      if (done) got = 1;
    end
    chk("t4_b2b_done", got, 1);
    repeat (2) @(posedge Clock);

    // T5: stray starts mid-block
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    run_block(1'b0, 1'b0, 5'd2, 5'd3, 5, 50, 1'b0);
    chk("t5_count", nw, 128);
    chk("t5_done_edge", de, 130);

    // T6: async reset after the 10th write
    @(negedge Clock);
    Y_finished = 1'b0; U_finished = 1'b0; Rb = 5'd0; Cb = 5'd0; start = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 10; i++) begin
      @(posedge Clock);
      #1;
      if (!SRAM_we_n) cnt++;
    end
    chk("t6_ten_writes", cnt, 10);
    #2 Resetn = 1'b0;
    #1;
    chk("t6_we_n", {31'd0, SRAM_we_n}, 32'd1);
    chk("t6_addr", {14'd0, SRAM_address}, 32'd0);
    chk("t6_data", {16'd0, SRAM_write_data}, 32'd0);
    chk("t6_dp", {24'd0, DP_RAM_address}, 32'd0);
    chk("t6_done", {31'd0, done}, 32'd0);
    repeat (3) begin
      @(posedge Clock);
      #1;
      chk("t6_hold_we_n", {31'd0, SRAM_we_n}, 32'd1);
      chk("t6_hold_done", {31'd0, done}, 32'd0);
    end
    @(negedge Clock);
    Resetn = 1'b1;
    run_block(1'b0, 1'b0, 5'd1, 5'd4, -1, -1, 1'b0);
    chk("t6_count", nw, 128);
    chk("t6_first", {14'd0, waddr[0]}, 32'd2592);
    chk("t6_done_edge", de, 130);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
